pep_mmacc_gram_feed_garb: RTL and testbench

PEP_MMACC_GRAM_FEED_GARB -- requirements
Module: pep_mmacc_gram_feed_garb

---
 rtl/pep_mmacc_common_param_pkg.sv | 24 ++
 rtl/pep_mmacc_gram_feed_garb_if.sv | 25 ++
 rtl/pep_mmacc_gram_feed_garb_slot.sv | 46 ++++
 rtl/pep_mmacc_gram_feed_garb.sv | 76 +++++++
 tb/tb_pep_mmacc_gram_feed_garb.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pep_mmacc_common_param_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pep_mmacc_common_param_pkg : GRAM arbitration parameters and request format
// Rev 1.0
// ----------------------------------------------------------------------------
package pep_mmacc_common_param_pkg;

  localparam int unsigned GRAM_NB    = 4;
  localparam int unsigned GRAM_ID_W  = 3;
  localparam int unsigned GARB_LEN_W = 4;
  localparam int unsigned GARB_CMD_W = GRAM_ID_W + GARB_LEN_W;

  // len is cycles-minus-one: len=0 requests a single read slot
  typedef struct packed {
    logic [GRAM_ID_W-1:0]  gram_id;
    logic [GARB_LEN_W-1:0] len;
  } garb_cmd_t;

  function automatic logic gram_id_legal(input logic [GRAM_ID_W-1:0] id);
    return id < GRAM_ID_W'(GRAM_NB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pep_mmacc_gram_feed_garb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pep_mmacc_gram_feed_garb_if : feed read-access request handshake
// Rev 1.0
// ----------------------------------------------------------------------------
interface pep_mmacc_gram_feed_garb_if;

  pep_mmacc_common_param_pkg::garb_cmd_t feed_garb_req;
  logic                                  feed_garb_req_vld;
  logic                                  feed_garb_req_rdy;

  modport master (
    output feed_garb_req,
    output feed_garb_req_vld,
    input  feed_garb_req_rdy
  );

  modport slave (
    input  feed_garb_req,
    input  feed_garb_req_vld,
    output feed_garb_req_rdy
  );

endinterface
`default_nettype wire

// File: rtl/pep_mmacc_gram_feed_garb_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pep_mmacc_gram_feed_garb_slot : per-GRAM read-slot counter and grant logic
// Rev 1.0
// ----------------------------------------------------------------------------
module pep_mmacc_gram_feed_garb_slot
  import pep_mmacc_common_param_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  a_rst_n,
  input  wire logic                  req,
  input  wire logic [GARB_LEN_W-1:0] len,
  input  wire logic                  busy,
  output logic                       grant,
  output logic                       rot_avail
);

  localparam logic [GARB_LEN_W:0] CNT_ONE = (GARB_LEN_W+1)'(1);

  logic [GARB_LEN_W:0] cnt;
  logic [GARB_LEN_W:0] cnt_nxt;

  // Granting on the last slot (cnt==1) chains windows without a bubble
  assign grant = req && (cnt <= CNT_ONE) && !busy;

  always_comb begin
    cnt_nxt = cnt;
    if (grant) begin
      cnt_nxt = {1'b0, len} + CNT_ONE;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      cnt       <= '0;
      rot_avail <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      rot_avail <= (cnt_nxt != '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pep_mmacc_gram_feed_garb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pep_mmacc_gram_feed_garb : feed-port GRAM read-slot arbiter with data strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module pep_mmacc_gram_feed_garb
  import pep_mmacc_common_param_pkg::*;
#(
  parameter int DATA_LATENCY = 5
) (
  input  wire logic                clk,
  input  wire logic                a_rst_n,
  pep_mmacc_gram_feed_garb_if.slave feed,
  input  wire logic [GRAM_NB-1:0]  other_gram_busy,
  output logic [GRAM_NB-1:0]       garb_feed_rot_avail_1h,
  output logic [GRAM_NB-1:0]       garb_feed_dat_avail_1h,
  output logic                     garb_error
);

  logic         init_done;
  logic         pend_vld;
  garb_cmd_t    pend;
  logic         accept;
  logic [GRAM_NB-1:0] grant;

  // init_done keeps rdy low while in reset and until the first edge after it
  assign feed.feed_garb_req_rdy = init_done && !pend_vld;
  assign accept = feed.feed_garb_req_vld && feed.feed_garb_req_rdy;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      init_done  <= 1'b0;
      pend_vld   <= 1'b0;
      pend       <= '0;
      garb_error <= 1'b0;
    end else begin
      init_done  <= 1'b1;
      garb_error <= accept && !gram_id_legal(feed.feed_garb_req.gram_id);
      if (accept) begin
        pend_vld <= 1'b1;
        pend     <= feed.feed_garb_req;
      end else if (pend_vld && ((grant != '0) || !gram_id_legal(pend.gram_id))) begin
        pend_vld <= 1'b0;
      end
    end
  end

  generate
    for (genvar g = 0; g < int'(GRAM_NB); g++) begin : g_slot
      pep_mmacc_gram_feed_garb_slot u_slot (
        .clk       (clk),
        .a_rst_n   (a_rst_n),
        .req       (pend_vld && (pend.gram_id == GRAM_ID_W'(g))),
        .len       (pend.len),
        .busy      (other_gram_busy[g]),
        .grant     (grant[g]),
        .rot_avail (garb_feed_rot_avail_1h[g])
      );
    end
  endgenerate

  logic [GRAM_NB-1:0] dat_pipe [DATA_LATENCY];

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int i = 0; i < DATA_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      dat_pipe[0] <= garb_feed_rot_avail_1h;
      for (int i = 1; i < DATA_LATENCY; i++) dat_pipe[i] <= dat_pipe[i-1];
    end
  end

  assign garb_feed_dat_avail_1h = dat_pipe[DATA_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_pep_mmacc_gram_feed_garb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pep_mmacc_gram_feed_garb : scoreboard bench for the feed GRAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pep_mmacc_gram_feed_garb;
  import pep_mmacc_common_param_pkg::*;

  localparam int DL   = 5;
  localparam int NCYC = 40;

  logic               clk = 1'b0;
  logic               a_rst_n = 1'b0;
  logic [GRAM_NB-1:0] other_gram_busy;
  logic [GRAM_NB-1:0] rot;
  logic [GRAM_NB-1:0] dat;
  logic               garb_error;

  pep_mmacc_gram_feed_garb_if bus ();

  pep_mmacc_gram_feed_garb #(.DATA_LATENCY(DL)) dut (
    .clk                    (clk),
    .a_rst_n                (a_rst_n),
    .feed                   (bus),
    .other_gram_busy        (other_gram_busy),
    .garb_feed_rot_avail_1h (rot),
    .garb_feed_dat_avail_1h (dat),
    .garb_error             (garb_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [GRAM_NB-1:0] rot;
    logic [GRAM_NB-1:0] dat;
    logic               err;
    logic               rdy;
  } exp_t;

  exp_t               sb_q [$];
  exp_t               e_tab  [NCYC];
  logic               s_vld  [NCYC];
  garb_cmd_t          s_req  [NCYC];
  logic [GRAM_NB-1:0] s_busy [NCYC];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_scn();
    for (int k = 0; k < NCYC; k++) begin
      e_tab[k]  = '{rot: '0, dat: '0, err: 1'b0, rdy: 1'b1};
      s_vld[k]  = 1'b0;
      s_req[k]  = '0;
      s_busy[k] = '0;
    end
  endtask

  // Request offered in cycle t while rdy is high; rdy drops for the pending cycle
  task automatic add_req(input int t, input int id, input int len);
    s_vld[t]         = 1'b1;
    s_req[t].gram_id = GRAM_ID_W'(id);
    s_req[t].len     = GARB_LEN_W'(len);
    e_tab[t+1].rdy   = 1'b0;
  endtask

  task automatic add_win(input int g, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      e_tab[start+i].rot[g]    = 1'b1;
      e_tab[start+i+DL].dat[g] = 1'b1;
    end
  endtask

  task automatic run_scn(input string name, input int ncyc);
    exp_t e;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      bus.feed_garb_req_vld = s_vld[k];
      bus.feed_garb_req     = s_req[k];
      other_gram_busy       = s_busy[k];
      sb_q.push_back(e_tab[k]);
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("%s.rot@%0d", name, k), 32'(rot),                   32'(e.rot));
      chk($sformatf("%s.dat@%0d", name, k), 32'(dat),                   32'(e.dat));
      chk($sformatf("%s.err@%0d", name, k), 32'(garb_error),            32'(e.err));
      chk($sformatf("%s.rdy@%0d", name, k), 32'(bus.feed_garb_req_rdy), 32'(e.rdy));
    end
    bus.feed_garb_req_vld = 1'b0;
    other_gram_busy       = '0;
  endtask

  logic [GRAM_NB-1:0] acc;

  initial begin
    bus.feed_garb_req_vld = 1'b0;
    bus.feed_garb_req     = '0;
    other_gram_busy       = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", 32'(bus.feed_garb_req_rdy), 32'd0);
    chk("rst.rot", 32'(rot), 32'd0);
    chk("rst.dat", 32'(dat), 32'd0);
    chk("rst.err", 32'(garb_error), 32'd0);
    @(posedge clk);
    #1 a_rst_n = 1'b1;
    #1 chk("rel.rdy_before_edge", 32'(bus.feed_garb_req_rdy), 32'd0);
    @(posedge clk);
    #1 chk("rel.rdy_first_edge", 32'(bus.feed_garb_req_rdy), 32'd1);

    clear_scn(); add_req(1, 2, 3); add_win(2, 3, 4);
    run_scn("basic", NCYC);

    clear_scn(); add_req(1, 1, 1); add_req(3, 1, 0); add_win(1, 3, 2); add_win(1, 5, 1);
    run_scn("chain", NCYC);

    clear_scn(); add_req(1, 0, 0);
    for (int k = 1; k <= 10; k++) s_busy[k] = 4'b0001;
    for (int k = 2; k <= 11; k++) e_tab[k].rdy = 1'b0;
    add_win(0, 12, 1);
    run_scn("block", NCYC);

    clear_scn(); add_req(1, 0, 7); add_req(3, 3, 7); add_win(0, 3, 8); add_win(3, 5, 8);
    run_scn("conc", NCYC);

    clear_scn(); add_req(1, 1, 15); add_win(1, 3, 16);
    run_scn("maxlen", NCYC);

    clear_scn(); add_req(1, int'(GRAM_NB), 0); e_tab[2].err = 1'b1;
    add_req(5, 7, 2); e_tab[6].err = 1'b1;
    run_scn("illegal", 20);

    clear_scn(); add_req(1, 2, 15); add_win(2, 3, 16);
    run_scn("rstmid", 8);
    #2 a_rst_n = 1'b0;
    #1;
    chk("rstmid.async_rot", 32'(rot), 32'd0);
    chk("rstmid.async_dat", 32'(dat), 32'd0);
    chk("rstmid.async_err", 32'(garb_error), 32'd0);
    chk("rstmid.async_rdy", 32'(bus.feed_garb_req_rdy), 32'd0);
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rstmid.rdy_first_edge", 32'(bus.feed_garb_req_rdy), 32'd1);
    acc = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      acc = acc | dat | rot;
    end
    chk("rstmid.no_avail_after", 32'(acc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
